sar_adc_ctrl: RTL



---
 rtl/sar_adc_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: synchronises the comparator decision,
// binary-searches N bits through the DAC trial code and publishes the result.
module sar_adc_ctrl #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         cmp_in,
  output logic         sample,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         result_valid
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(N);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [N-1:0]     r_work, w_work_nxt;
  logic [N-1:0]     r_dac, w_dac_nxt;
  logic [N-1:0]     r_result, w_result_nxt;
  logic             r_rvalid, w_rvalid_nxt;
  logic [N-1:0]     w_decided;
  logic [N-1:0]     w_trial_top;
  logic [N-1:0]     w_trial_next;

  // Trial code: decided upper bits plus the bit currently under test.
  function automatic logic [N-1:0] f_trial(input logic [N-1:0] w, input logic [IDX_W-1:0] i);
    return w | (N'(1) << i);
  endfunction

  function automatic logic [N-1:0] f_setbit(input logic [N-1:0] w, input logic [IDX_W-1:0] i,
                                            input logic b);
    return b ? (w | (N'(1) << i)) : (w & ~(N'(1) << i));
  endfunction

  assign w_decided    = f_setbit(r_work, r_idx, r_sync2);
  assign w_trial_top  = f_trial(r_work, IDX_TOP);
  assign w_trial_next = f_trial(w_decided, r_idx - IDX_W'(1));

  // cmp_in is asynchronous to clk; only the second flop is ever used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= cmp_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_work   <= '0;
      r_dac    <= '0;
      r_result <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_work   <= w_work_nxt;
      r_dac    <= w_dac_nxt;
      r_result <= w_result_nxt;
      r_rvalid <= w_rvalid_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_work_nxt   = r_work;
    w_dac_nxt    = r_dac;
    w_result_nxt = r_result;
    w_rvalid_nxt = r_rvalid;
    sample       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (r_state)
      S_IDLE: begin
        // abort wins over a simultaneous start request
        if (start && !abort) begin
          w_state_nxt = S_SAMPLE;
          w_cnt_nxt   = '0;
          w_work_nxt  = '0;
          w_dac_nxt   = '0;
        end
      end
      S_SAMPLE: begin
        sample = 1'b1;
        busy   = 1'b1;
        if (r_cnt == SAMPLE_LAST) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = IDX_TOP;
          w_dac_nxt   = w_trial_top;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = S_DECIDE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DECIDE: begin
        busy       = 1'b1;
        w_work_nxt = w_decided;
        if (r_idx != '0) begin
          w_state_nxt = S_SETTLE;
          w_idx_nxt   = r_idx - IDX_W'(1);
          w_dac_nxt   = w_trial_next;
        end else begin
          w_state_nxt  = S_DONE;
          w_dac_nxt    = w_decided;
          w_result_nxt = w_decided;
          w_rvalid_nxt = 1'b1;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
        w_dac_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_dac_nxt   = '0;
      end
    endcase

    // Cancel leaves the published result untouched.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = '0;
      w_dac_nxt    = '0;
      w_result_nxt = r_result;
      w_rvalid_nxt = r_rvalid;
    end
  end

  assign dac_code     = r_dac;
  assign result       = r_result;
  assign result_valid = r_rvalid;

endmodule
